// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the pipelined fetch stage.
// Default widths, the buffer entry layout, the PC increment and the
// pointer-width helper used by fetch_stage_q and fetch_buffer.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 9;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  // One prefetch buffer slot at the default widths.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
    logic                     filled;
  } fetch_entry_t;

  // Pointers carry one extra wrap bit so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order ring buffer of DEPTH fetch slots with alloc/fill/head pointers.
// Latency: alloc/fill/pop take effect at the next edge; head outputs are registered state.
// Backpressure: caller must not alloc when full; flush drops every entry (head=fill=alloc).
// Ports: i_alloc/i_alloc_pc reserve a slot, i_fill/i_fill_data complete the oldest
// unfilled slot, i_pop retires the head, i_flush empties; o_head_* show the head slot,
// o_occupancy = alloc-head, o_unfilled = alloc-fill.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = 4,
  parameter int PW      = ptr_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic [ADDR_W-1:0]  i_alloc_pc,
  input  logic               i_fill,
  input  logic [INSTR_W-1:0] i_fill_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic               o_head_vld,
  output logic [ADDR_W-1:0]  o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr,
  output logic [PW-1:0]      o_occupancy,
  output logic [PW-1:0]      o_unfilled
);

  localparam int IW = PW - 1;

  logic [PW-1:0]      r_alloc;
  logic [PW-1:0]      r_fill;
  logic [PW-1:0]      r_head;
  logic [ADDR_W-1:0]  r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [DEPTH-1:0]   r_filled;

  logic [IW-1:0] w_alloc_idx;
  logic [IW-1:0] w_fill_idx;
  logic [IW-1:0] w_head_idx;

  assign w_alloc_idx = r_alloc[IW-1:0];
  assign w_fill_idx  = r_fill[IW-1:0];
  assign w_head_idx  = r_head[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc  <= '0;
      r_fill   <= '0;
      r_head   <= '0;
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_flush) begin
      // Slots keep stale contents; the empty check on head masks them and
      // the next alloc clears the filled flag.
      r_fill <= r_alloc;
      r_head <= r_alloc;
    end else begin
      // Alloc and fill never hit the same slot: that would need
      // alloc-fill == DEPTH, and alloc is blocked when full.
      if (i_alloc) begin
        r_pc[w_alloc_idx]     <= i_alloc_pc;
        r_filled[w_alloc_idx] <= 1'b0;
        r_alloc               <= r_alloc + 1'b1;
      end
      if (i_fill) begin
        r_instr[w_fill_idx]  <= i_fill_data;
        r_filled[w_fill_idx] <= 1'b1;
        r_fill               <= r_fill + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  assign o_head_vld   = (r_head != r_alloc) && r_filled[w_head_idx];
  assign o_head_pc    = r_pc[w_head_idx];
  assign o_head_instr = r_instr[w_head_idx];
  assign o_occupancy  = r_alloc - r_head;
  assign o_unfilled   = r_alloc - r_fill;

endmodule

// File: rtl/fetch_stage_q.sv
// fetch_stage_q: PC generator + prefetch buffer between execute PC-select and decode.
// Latency: request at t, response at t+L -> ValidD at t+L+1 (2 cycles minimum).
// Backpressure: requests gated by credit (occupancy + owed drops < DEPTH); ReadyD holds the head.
// Ports: PCSrcE/PCTargetE redirect; imem_req_* issue fetches (valid independent of ready);
// imem_rsp_* return data in order, never backpressured; ValidD/ReadyD/InstrD/PCD/PCPlus4D
// present the oldest filled instruction to decode (data outputs are 0 while ValidD=0).
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = FETCH_ADDR_W,
  parameter int               INSTR_W  = FETCH_INSTR_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrcE,
  input  logic [ADDR_W-1:0]  PCTargetE,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               ValidD,
  input  logic               ReadyD,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCD,
  output logic [ADDR_W-1:0]  PCPlus4D
);

  localparam int            PW      = ptr_w(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] r_pc;
  logic [PW-1:0]     r_drop_cnt;

  logic              w_credit;
  logic [PW:0]       w_inflight;
  logic              w_req_fire;
  logic              w_drop_active;
  logic              w_fill;
  logic              w_pop;
  logic              w_alloc;
  logic              w_head_vld;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PW-1:0]     w_occupancy;
  logic [PW-1:0]     w_unfilled;

  // Responses still owed for flushed requests occupy credit too, so a
  // redirect cannot let new requests outrun the memory's response queue.
  assign w_inflight     = {1'b0, w_occupancy} + {1'b0, r_drop_cnt};
  assign w_credit       = w_inflight < DEPTH_C;
  assign imem_req_valid = !rst && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_drop_active  = (r_drop_cnt != '0);
  // In the redirect cycle everything at the old PC is discarded: the firing
  // request is counted as dropped, an arriving response is not written,
  // and a pop is suppressed.
  assign w_alloc        = w_req_fire && !PCSrcE;
  assign w_fill         = imem_rsp_valid && !w_drop_active && !PCSrcE;
  assign w_pop          = w_head_vld && ReadyD && !PCSrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (PCSrcE) begin
      r_pc <= PCTargetE;
    end else if (w_req_fire) begin
      r_pc <= r_pc + STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (PCSrcE) begin
      // Owed = already owed + unfilled slots + this cycle's request,
      // less the response (dropped or not) that arrives now.
      r_drop_cnt <= r_drop_cnt + w_unfilled + PW'(w_req_fire) - PW'(imem_rsp_valid);
    end else if (imem_rsp_valid && w_drop_active) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PW      (PW)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_data  (imem_rsp_data),
    .i_pop        (w_pop),
    .i_flush      (PCSrcE),
    .o_head_vld   (w_head_vld),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_occupancy  (w_occupancy),
    .o_unfilled   (w_unfilled)
  );

  // Data outputs are zeroed while no valid head exists, so reset and empty
  // states show 0 on all three rather than stale slot contents.
  assign ValidD   = w_head_vld;
  assign InstrD   = w_head_vld ? w_head_instr : '0;
  assign PCD      = w_head_vld ? w_head_pc : '0;
  assign PCPlus4D = w_head_vld ? (w_head_pc + STEP) : '0;

endmodule

// File: tb/tb_fetch_stage_q.sv
// tb_fetch_stage_q: directed bench for fetch_stage_q with an in-order fixed-latency memory.
// Latency: memory answers a request accepted in cycle t during cycle t+lat.
// Backpressure: imem_req_ready held high; ReadyD driven by the directed sequence.
`timescale 1ns/1ps
module tb_fetch_stage_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [8:0]  PCTargetE = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [8:0]  imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        ValidD;
  logic        ReadyD = 1'b1;
  logic [31:0] InstrD;
  logic [8:0]  PCD;
  logic [8:0]  PCPlus4D;

  int checks = 0;
  int failures = 0;

  logic [8:0] mq_addr[$];
  int         mq_due[$];
  int         cyc = 0;
  int         lat = 1;

  fetch_stage_q dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ValidD         (ValidD),
    .ReadyD         (ReadyD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [8:0] a);
    return 32'hA500_0000 | {23'h0, a};
  endfunction

  // Memory model: capture handshakes mid-cycle, answer in order lat cycles later.
  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mq_due.size() != 0 && mq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    nxt(); nxt();
    chk("rst_validd", {31'h0, ValidD}, 32'h1 & 32'h0);
    chk("rst_reqvld", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_pcd", {23'h0, PCD}, 32'h0);
    chk("rst_pcp4", {23'h0, PCPlus4D}, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_addr", {23'h0, imem_req_addr}, 32'h0);

    // Streaming, L=1, ReadyD=1
    rst = 1'b0; #1;
    chk("s_c0_vld", {31'h0, imem_req_valid}, 32'h1);
    chk("s_c0_addr", {23'h0, imem_req_addr}, 32'h0);
    nxt();
    chk("s_c1_addr", {23'h0, imem_req_addr}, 32'h4);
    chk("s_c1_validd", {31'h0, ValidD}, 32'h0);
    nxt();
    chk("s_c2_validd", {31'h0, ValidD}, 32'h1);
    chk("s_c2_pcd", {23'h0, PCD}, 32'h0);
    chk("s_c2_pcp4", {23'h0, PCPlus4D}, 32'h4);
    chk("s_c2_instr", InstrD, instr_of(9'h000));
    chk("s_c2_addr", {23'h0, imem_req_addr}, 32'h8);
    nxt();
    chk("s_c3_pcd", {23'h0, PCD}, 32'h4);
    nxt();
    chk("s_c4_pcd", {23'h0, PCD}, 32'h8);
    chk("s_c4_pcp4", {23'h0, PCPlus4D}, 32'hC);

    // Reset mid-stream with filled entries
    rst = 1'b1; #1;
    chk("mr_validd", {31'h0, ValidD}, 32'h0);
    chk("mr_reqvld", {31'h0, imem_req_valid}, 32'h0);
    chk("mr_pcd", {23'h0, PCD}, 32'h0);

    // Decode stalled: buffer fills after 4 requests
    ReadyD = 1'b0;
    nxt(); nxt();
    rst = 1'b0; #1;
    chk("st_c0_vld", {31'h0, imem_req_valid}, 32'h1);
    chk("st_c0_addr", {23'h0, imem_req_addr}, 32'h0);
    repeat (4) nxt();
    chk("st_c4_reqvld", {31'h0, imem_req_valid}, 32'h0);
    chk("st_c4_validd", {31'h0, ValidD}, 32'h1);
    chk("st_c4_pcd", {23'h0, PCD}, 32'h0);
    nxt(); nxt();
    chk("st_c6_reqvld", {31'h0, imem_req_valid}, 32'h0);
    chk("st_c6_pcd", {23'h0, PCD}, 32'h0);
    ReadyD = 1'b1;
    nxt();
    chk("st_c7_reqvld", {31'h0, imem_req_valid}, 32'h1);
    chk("st_c7_addr", {23'h0, imem_req_addr}, 32'h10);
    chk("st_c7_pcd", {23'h0, PCD}, 32'h4);
    nxt();
    chk("st_c8_pcd", {23'h0, PCD}, 32'h8);
    nxt();
    chk("st_c9_pcd", {23'h0, PCD}, 32'hC);
    nxt();
    chk("st_c10_pcd", {23'h0, PCD}, 32'h10);
    chk("st_c10_instr", InstrD, instr_of(9'h010));

    // L=3, redirect with two outstanding plus one firing
    rst = 1'b1;
    nxt();
    lat = 3;
    nxt();
    rst = 1'b0; #1;
    chk("rd_c0_addr", {23'h0, imem_req_addr}, 32'h0);
    nxt(); nxt();
    chk("rd_c2_reqvld", {31'h0, imem_req_valid}, 32'h1);
    chk("rd_c2_addr", {23'h0, imem_req_addr}, 32'h8);
    PCSrcE = 1'b1; PCTargetE = 9'h040;
    nxt();
    PCSrcE = 1'b0;
    chk("rd_c3_addr", {23'h0, imem_req_addr}, 32'h40);
    chk("rd_c3_validd", {31'h0, ValidD}, 32'h0);
    for (int i = 4; i <= 6; i++) begin
      nxt();
      chk($sformatf("rd_c%0d_validd", i), {31'h0, ValidD}, 32'h0);
    end
    nxt();
    chk("rd_c7_validd", {31'h0, ValidD}, 32'h1);
    chk("rd_c7_pcd", {23'h0, PCD}, 32'h40);
    chk("rd_c7_instr", InstrD, instr_of(9'h040));
    nxt();
    chk("rd_c8_pcd", {23'h0, PCD}, 32'h44);
    chk("rd_c8_validd", {31'h0, ValidD}, 32'h1);

    // Redirect coinciding with a pop, a response and a request; target near wrap
    PCSrcE = 1'b1; PCTargetE = 9'h1F8;
    nxt();
    PCSrcE = 1'b0;
    chk("wr_c9_addr", {23'h0, imem_req_addr}, 32'h1F8);
    chk("wr_c9_validd", {31'h0, ValidD}, 32'h0);
    nxt();
    chk("wr_c10_addr", {23'h0, imem_req_addr}, 32'h1FC);
    nxt();
    chk("wr_c11_addr", {23'h0, imem_req_addr}, 32'h0);
    nxt();
    chk("wr_c12_validd", {31'h0, ValidD}, 32'h0);
    nxt();
    chk("wr_c13_validd", {31'h0, ValidD}, 32'h1);
    chk("wr_c13_pcd", {23'h0, PCD}, 32'h1F8);
    nxt();
    chk("wr_c14_pcd", {23'h0, PCD}, 32'h1FC);
    chk("wr_c14_pcp4", {23'h0, PCPlus4D}, 32'h0);
    chk("wr_c14_instr", InstrD, instr_of(9'h1FC));
    nxt();
    chk("wr_c15_pcd", {23'h0, PCD}, 32'h0);
    chk("wr_c15_pcp4", {23'h0, PCPlus4D}, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
